// File: rtl/rns_9_8_7_pkg.sv
// Shared types and helpers for the (9,8,7) residue number system blocks.
package rns_9_8_7_pkg;

  localparam int R9_W      = 4;
  localparam int R8_W      = 3;
  localparam int R7_W      = 3;
  localparam int RNS_RANGE = 504;
  localparam int BIN_W     = 9;

  // One operand as its three residues.
  typedef struct packed {
    logic [R9_W-1:0] r9;
    logic [R8_W-1:0] r8;
    logic [R7_W-1:0] r7;
  } rns_t;

  // Scanner FSM states.
  typedef enum logic [2:0] {
    S_FIRST = 3'd0,
    S_WAIT  = 3'd1,
    S_CMAX  = 3'd2,
    S_CMIN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // CRT reconstruction: X = (280*r9 + 441*r8 + 288*r7) mod 504.
  // The weighted sum is below 16*504, so four conditional subtractions
  // of 504*{8,4,2,1} fully reduce it without a general divider.
  function automatic logic [BIN_W-1:0] rns_to_bin(
    input logic [R9_W-1:0] r9,
    input logic [R8_W-1:0] r8,
    input logic [R7_W-1:0] r7
  );
    logic [12:0] acc;
    acc = 13'd280 * {9'd0, r9} + 13'd441 * {10'd0, r8} + 13'd288 * {10'd0, r7};
    if (acc >= 13'd4032) acc = acc - 13'd4032;
    if (acc >= 13'd2016) acc = acc - 13'd2016;
    if (acc >= 13'd1008) acc = acc - 13'd1008;
    if (acc >= 13'd504)  acc = acc - 13'd504;
    return BIN_W'(acc);
  endfunction

endpackage

// File: rtl/rns_minmax_scan_9_8_7_compare.sv
// Magnitude comparator for two (9,8,7) RNS operands: x versus y.
module compare_9_8_7
  import rns_9_8_7_pkg::*;
(
  input  logic [R9_W-1:0] x1,
  input  logic [R8_W-1:0] x2,
  input  logic [R7_W-1:0] x3,
  input  logic [R9_W-1:0] y1,
  input  logic [R8_W-1:0] y2,
  input  logic [R7_W-1:0] y3,
  output logic            le,
  output logic            eq,
  output logic            gr
);

  logic [BIN_W-1:0] w_xBin;
  logic [BIN_W-1:0] w_yBin;

  assign w_xBin = rns_to_bin(x1, x2, x3);
  assign w_yBin = rns_to_bin(y1, y2, y3);

  // le means strictly less; exactly one of the three flags is set.
  always_comb begin
    le = (w_xBin <  w_yBin);
    eq = (w_xBin == w_yBin);
    gr = (w_xBin >  w_yBin);
  end

endmodule

// File: rtl/rns_minmax_scan_9_8_7.sv
// Streaming min/max scanner for (9,8,7) RNS items, one shared comparator.
module rns_minmax_scan_9_8_7
  import rns_9_8_7_pkg::*;
#(
  parameter int IDX_W = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [R9_W-1:0]  in_r9,
  input  logic [R8_W-1:0]  in_r8,
  input  logic [R7_W-1:0]  in_r7,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [R9_W-1:0]  max_r9,
  output logic [R8_W-1:0]  max_r8,
  output logic [R7_W-1:0]  max_r7,
  output logic [R9_W-1:0]  min_r9,
  output logic [R8_W-1:0]  min_r8,
  output logic [R7_W-1:0]  min_r7,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx,
  output logic [IDX_W:0]   count,
  output logic             ovf
);

  localparam logic [IDX_W:0] MAX_COUNT = {1'b1, {IDX_W{1'b0}}};

  state_t           r_state;
  state_t           w_nextState;
  rns_t             r_max;
  rns_t             r_min;
  rns_t             r_cur;
  logic [IDX_W-1:0] r_maxIdx;
  logic [IDX_W-1:0] r_minIdx;
  logic [IDX_W-1:0] r_curIdx;
  logic [IDX_W:0]   r_count;
  logic             r_curLast;
  logic             r_ovf;

  rns_t w_item;
  rns_t w_y;
  logic w_accept;
  logic w_release;
  logic w_le;
  logic w_eq;
  logic w_gr;
  logic w_endSeq;
  logic w_ovfHit;
  logic w_loadFirst;
  logic w_loadCur;
  logic w_updMax;
  logic w_updMin;
  logic w_setOvf;
  logic w_clrOvf;

  assign w_item    = '{r9: in_r9, r8: in_r8, r7: in_r7};
  assign in_ready  = (r_state == S_FIRST) || (r_state == S_WAIT);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // The comparator's y operand is the running min only while in S_CMIN.
  assign w_y = (r_state == S_CMIN) ? r_min : r_max;

  // A sequence ends on its marked last item or when the index space is full.
  assign w_endSeq = r_curLast || (r_count == MAX_COUNT);
  assign w_ovfHit = !r_curLast && (r_count == MAX_COUNT);

  compare_9_8_7 u_compare (
    .x1 (r_cur.r9),
    .x2 (r_cur.r8),
    .x3 (r_cur.r7),
    .y1 (w_y.r9),
    .y2 (w_y.r8),
    .y3 (w_y.r7),
    .le (w_le),
    .eq (w_eq),
    .gr (w_gr)
  );

  // Simulation-time guard: accepted residues must be canonical.
  assert property (@(posedge clk) disable iff (!rst_n)
                   w_accept |-> ((in_r9 < 4'd9) && (in_r7 < 3'd7)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FIRST;
    else        r_state <= w_nextState;
  end

  // Next state and datapath strobes; a new max skips the min compare.
  always_comb begin
    w_nextState = r_state;
    w_loadFirst = 1'b0;
    w_loadCur   = 1'b0;
    w_updMax    = 1'b0;
    w_updMin    = 1'b0;
    w_setOvf    = 1'b0;
    w_clrOvf    = 1'b0;
    unique case (r_state)
      S_FIRST: begin
        if (w_accept) begin
          w_loadFirst = 1'b1;
          w_nextState = in_last ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_accept) begin
          w_loadCur   = 1'b1;
          w_nextState = S_CMAX;
        end
      end
      S_CMAX: begin
        if (w_gr) begin
          w_updMax    = 1'b1;
          w_setOvf    = w_ovfHit;
          w_nextState = w_endSeq ? S_DONE : S_WAIT;
        end else if (w_le || w_eq) begin
          w_nextState = S_CMIN;
        end
      end
      S_CMIN: begin
        w_updMin    = w_le;
        w_setOvf    = w_ovfHit;
        w_nextState = w_endSeq ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        if (w_release) begin
          w_clrOvf    = 1'b1;
          w_nextState = S_FIRST;
        end
      end
      default: w_nextState = S_FIRST;
    endcase
  end

  // Running extremes, current item, counters and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max     <= '0;
      r_min     <= '0;
      r_cur     <= '0;
      r_maxIdx  <= '0;
      r_minIdx  <= '0;
      r_curIdx  <= '0;
      r_count   <= '0;
      r_curLast <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_loadFirst) begin
        r_max    <= w_item;
        r_min    <= w_item;
        r_maxIdx <= '0;
        r_minIdx <= '0;
        r_count  <= (IDX_W+1)'(1);
      end
      if (w_loadCur) begin
        r_cur     <= w_item;
        r_curIdx  <= r_count[IDX_W-1:0];
        r_count   <= r_count + (IDX_W+1)'(1);
        r_curLast <= in_last;
      end
      if (w_updMax) begin
        r_max    <= r_cur;
        r_maxIdx <= r_curIdx;
      end
      if (w_updMin) begin
        r_min    <= r_cur;
        r_minIdx <= r_curIdx;
      end
      if (w_setOvf)      r_ovf <= 1'b1;
      else if (w_clrOvf) r_ovf <= 1'b0;
    end
  end

  assign max_r9  = r_max.r9;
  assign max_r8  = r_max.r8;
  assign max_r7  = r_max.r7;
  assign min_r9  = r_min.r9;
  assign min_r8  = r_min.r8;
  assign min_r7  = r_min.r7;
  assign max_idx = r_maxIdx;
  assign min_idx = r_minIdx;
  assign count   = r_count;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_rns_minmax_scan_9_8_7.sv
// Directed scoreboard bench for rns_minmax_scan_9_8_7 (IDX_W=8 and IDX_W=2).
module tb_rns_minmax_scan_9_8_7;

  typedef struct {
    int maxV;
    int minV;
    int maxIdx;
    int minIdx;
    int cnt;
    int ovfV;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic [3:0] in_r9;
  logic [2:0] in_r8;
  logic [2:0] in_r7;
  int         cyc = 0;

  logic       aInReady, aOutValid, aOvf;
  logic [3:0] aMaxR9, aMinR9;
  logic [2:0] aMaxR8, aMaxR7, aMinR8, aMinR7;
  logic [7:0] aMaxIdx, aMinIdx;
  logic [8:0] aCount;

  logic       bInReady, bOutValid, bOvf;
  logic [3:0] bMaxR9, bMinR9;
  logic [2:0] bMaxR8, bMaxR7, bMinR8, bMinR7;
  logic [1:0] bMaxIdx, bMinIdx;
  logic [2:0] bCount;

  logic       inReady, outValid, ovfM;
  logic [9:0] maxPacked, minPacked;
  logic [7:0] maxIdxM, minIdxM;
  logic [8:0] countM;

  exp_t expQ[$];
  int   stimQ[$];
  int   acceptCyc[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rns_minmax_scan_9_8_7 #(.IDX_W(8)) u_dutA (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && !sel), .in_ready(aInReady),
    .in_r9(in_r9), .in_r8(in_r8), .in_r7(in_r7), .in_last(in_last),
    .out_valid(aOutValid), .out_ready(out_ready && !sel),
    .max_r9(aMaxR9), .max_r8(aMaxR8), .max_r7(aMaxR7),
    .min_r9(aMinR9), .min_r8(aMinR8), .min_r7(aMinR7),
    .max_idx(aMaxIdx), .min_idx(aMinIdx), .count(aCount), .ovf(aOvf)
  );

  rns_minmax_scan_9_8_7 #(.IDX_W(2)) u_dutB (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel), .in_ready(bInReady),
    .in_r9(in_r9), .in_r8(in_r8), .in_r7(in_r7), .in_last(in_last),
    .out_valid(bOutValid), .out_ready(out_ready && sel),
    .max_r9(bMaxR9), .max_r8(bMaxR8), .max_r7(bMaxR7),
    .min_r9(bMinR9), .min_r8(bMinR8), .min_r7(bMinR7),
    .max_idx(bMaxIdx), .min_idx(bMinIdx), .count(bCount), .ovf(bOvf)
  );

  assign inReady   = sel ? bInReady  : aInReady;
  assign outValid  = sel ? bOutValid : aOutValid;
  assign ovfM      = sel ? bOvf      : aOvf;
  assign maxPacked = sel ? {bMaxR9, bMaxR8, bMaxR7} : {aMaxR9, aMaxR8, aMaxR7};
  assign minPacked = sel ? {bMinR9, bMinR8, bMinR7} : {aMinR9, aMinR8, aMinR7};
  assign maxIdxM   = sel ? {6'd0, bMaxIdx} : aMaxIdx;
  assign minIdxM   = sel ? {6'd0, bMinIdx} : aMinIdx;
  assign countM    = sel ? {6'd0, bCount}  : aCount;

  function automatic int packRns(input int v);
    return ((v % 9) << 6) | ((v % 8) << 3) | (v % 7);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutValid();
    int waited;
    waited = 0;
    while (!outValid && waited < 2000) begin
      tick();
      waited++;
    end
    if (!outValid) checkVal("out_valid_timeout", 32'(outValid), 1);
  endtask

  // Pops the oldest expected result, compares every field, then releases it.
  task automatic checkOutput();
    exp_t e;
    waitOutValid();
    if (!outValid) return;
    if (expQ.size() == 0) begin
      checkVal("scoreboard_underflow", 32'(expQ.size()), 1);
      return;
    end
    e = expQ.pop_front();
    checkVal("max_residues", 32'(maxPacked), packRns(e.maxV));
    checkVal("min_residues", 32'(minPacked), packRns(e.minV));
    checkVal("max_idx", 32'(maxIdxM), e.maxIdx);
    checkVal("min_idx", 32'(minIdxM), e.minIdx);
    checkVal("count", 32'(countM), e.cnt);
    checkVal("ovf", 32'(ovfM), e.ovfV);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkVal("in_ready_after_release", 32'(inReady), 1);
    checkVal("out_valid_after_release", 32'(outValid), 0);
  endtask

  // Offers one item and holds it until accepted, draining results meanwhile.
  task automatic sendItem(input int v, input bit last);
    int waited;
    waited = 0;
    in_r9    = 4'(v % 9);
    in_r8    = 3'(v % 8);
    in_r7    = 3'(v % 7);
    in_last  = last;
    in_valid = 1'b1;
    while (!inReady && waited < 2000) begin
      if (outValid) checkOutput();
      else begin
        tick();
        waited++;
      end
    end
    if (!inReady) checkVal("in_ready_timeout", 32'(inReady), 1);
    tick();
    acceptCyc.push_back(cyc);
  endtask

  // Sends stimQ, pushing the reference result for each sequence it closes.
  task automatic applyStimulus(input bit lastOnEnd, input int limit);
    exp_t e;
    int   cnt;
    bit   isLast;
    cnt = 0;
    e   = '{0, 0, 0, 0, 0, 0};
    acceptCyc.delete();
    for (int i = 0; i < stimQ.size(); i++) begin
      if (cnt == 0) begin
        e.maxV = stimQ[i]; e.minV = stimQ[i];
        e.maxIdx = 0;      e.minIdx = 0;
      end else begin
        if (stimQ[i] > e.maxV) begin e.maxV = stimQ[i]; e.maxIdx = cnt; end
        if (stimQ[i] < e.minV) begin e.minV = stimQ[i]; e.minIdx = cnt; end
      end
      cnt++;
      isLast = lastOnEnd && (i == stimQ.size() - 1);
      if (isLast || cnt == limit) begin
        e.cnt  = cnt;
        e.ovfV = isLast ? 0 : 1;
        expQ.push_back(e);
        cnt = 0;
      end
      sendItem(stimQ[i], isLast);
    end
    in_valid = 1'b0;
    stimQ.delete();
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_r9 = '0; in_r8 = '0; in_r7 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_out_valid", 32'(outValid), 0);
    checkVal("reset_count", 32'(countM), 0);
    checkVal("reset_ovf", 32'(ovfM), 0);
    checkVal("reset_max", 32'(maxPacked), 0);
    checkVal("reset_max_idx", 32'(maxIdxM), 0);
    rst_n = 1'b1;
    tick();
    checkVal("ready_after_reset", 32'(inReady), 1);

    $display("[TB] single item");
    stimQ = '{100};
    applyStimulus(1'b1, 256);
    checkVal("single_latency", 32'(outValid), 1);
    checkOutput();

    $display("[TB] mixed sequence");
    stimQ = '{5, 300, 2, 300, 503};
    applyStimulus(1'b1, 256);
    checkOutput();

    $display("[TB] equal items");
    stimQ = '{7, 7, 7};
    applyStimulus(1'b1, 256);
    checkVal("tie_item1_gap", acceptCyc[1] - acceptCyc[0], 1);
    checkVal("tie_item2_gap", acceptCyc[2] - acceptCyc[1], 3);
    checkOutput();

    $display("[TB] ascending 0..251");
    for (int i = 0; i < 252; i++) stimQ.push_back(i);
    applyStimulus(1'b1, 256);
    checkVal("ascending_span", acceptCyc[251] - acceptCyc[0], 501);
    checkOutput();

    $display("[TB] output backpressure");
    stimQ = '{42, 500, 17};
    applyStimulus(1'b1, 256);
    waitOutValid();
    for (int i = 0; i < 5; i++) begin
      checkVal("hold_out_valid", 32'(outValid), 1);
      checkVal("hold_in_ready", 32'(inReady), 0);
      checkVal("hold_max", 32'(maxPacked), packRns(500));
      checkVal("hold_min", 32'(minPacked), packRns(17));
      tick();
    end
    checkOutput();

    $display("[TB] overflow with IDX_W=2");
    sel = 1'b1;
    tick();
    stimQ = '{10, 400, 3, 77, 200, 150};
    applyStimulus(1'b1, 4);
    while (expQ.size() > 0 && outValid) checkOutput();
    if (expQ.size() > 0) checkOutput();
    sel = 1'b0;
    tick();

    $display("[TB] reset mid-sequence");
    acceptCyc.delete();
    sendItem(50, 1'b0);
    sendItem(40, 1'b0);
    sendItem(30, 1'b0);
    sendItem(20, 1'b0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checkVal("midreset_out_valid", 32'(outValid), 0);
    checkVal("midreset_count", 32'(countM), 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkVal("midreset_in_ready", 32'(inReady), 1);
    stimQ = '{9, 8, 11};
    applyStimulus(1'b1, 256);
    checkOutput();

    checkVal("scoreboard_drained", 32'(expQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
